// File: rtl/fb_pkg.sv
// Shared framebuffer definitions for the access arbiter and its helpers.
//   FB_WIDTH/FB_HEIGHT/FB_SIZE : framebuffer geometry (one word per pixel)
//   ADDR_W/DATA_W              : RAM address and data widths
//   owner_e                    : which requester owns an issued RAM access
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 640;
  localparam int unsigned FB_HEIGHT = 480;
  localparam int unsigned FB_SIZE   = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnDisp = 2'd1,
    OwnCpu  = 2'd2
  } owner_e;

  // True when the address lies inside a framebuffer of 'size' words.
  function automatic logic in_range(logic [ADDR_W-1:0] addr, int unsigned size);
    return 32'(addr) < size;
  endfunction

endpackage

// File: rtl/fb_sat_counter.sv
// Saturating up-counter.
//   clock : clock
//   clear : synchronous clear to zero (has priority)
//   inc   : increment enable; the count sticks at all-ones
//   count : current count
module fb_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fb_access_arbiter.sv
// Framebuffer RAM arbiter between a display read port and a CPU read/write port.
// Display normally wins; a CPU request that has waited MAX_STARVE cycles is forced
// through, and the display request dropped in that cycle is reported as a miss.
//   clock, reset                       : clock, synchronous active-high reset
//   disp_req/disp_addr                 : display read request
//   disp_rdata/disp_rvalid/disp_miss   : display read return, dropped-request pulse
//   cpu_valid/cpu_ready/cpu_we/...     : CPU valid/ready request channel
//   cpu_rdata/cpu_rvalid/cpu_err       : CPU read return, out-of-range pulse
//   mem_*                              : RAM port (read data valid one cycle after mem_en)
//   miss_count                         : saturating count of display misses
module fb_access_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned MAX_STARVE = 16,
  parameter int unsigned FB_SIZE    = fb_pkg::FB_SIZE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  output logic              disp_miss,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       miss_count
);

  // MAX_STARVE = 0 forces every pending CPU request straight through.
  localparam int unsigned STARVE_W = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

  logic [STARVE_W-1:0] starve_cnt;
  logic                forced;
  logic                grant_disp;
  logic                grant_cpu;
  owner_e              grant;
  logic [ADDR_W-1:0]   gnt_addr;
  logic                gnt_oor;

  // Stage-1 bookkeeping for the access now on the RAM port.
  owner_e owner_q;
  logic   oor_q;
  logic   rd_q;
  logic   miss_q;

  always_comb begin
    forced     = cpu_valid && (starve_cnt == STARVE_MAX);
    grant_disp = disp_req && !forced;
    grant_cpu  = cpu_valid && !grant_disp;
    grant      = grant_disp ? OwnDisp : (grant_cpu ? OwnCpu : OwnNone);
    gnt_addr   = grant_disp ? disp_addr : (grant_cpu ? cpu_addr : '0);
    gnt_oor    = !in_range(gnt_addr, FB_SIZE);
  end

  assign cpu_ready = grant_cpu && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt  <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      owner_q     <= OwnNone;
      oor_q       <= 1'b0;
      rd_q        <= 1'b0;
      miss_q      <= 1'b0;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
      disp_miss   <= 1'b0;
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
      cpu_err     <= 1'b0;
    end else begin
      if (!cpu_valid || grant_cpu) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end

      // Stage 1: drive the RAM; out-of-range addresses never reach it.
      mem_en    <= (grant != OwnNone) && !gnt_oor;
      mem_we    <= grant_cpu && cpu_we && !gnt_oor;
      mem_addr  <= gnt_addr;
      mem_wdata <= (grant_cpu && cpu_we) ? cpu_wdata : '0;
      owner_q   <= grant;
      oor_q     <= gnt_oor;
      rd_q      <= !(grant_cpu && cpu_we);
      // A CPU grant while display is requesting can only be a forced one.
      miss_q    <= disp_req && grant_cpu;

      // Stage 2: return read data to the owner only; data regs hold otherwise.
      disp_rvalid <= (owner_q == OwnDisp);
      if (owner_q == OwnDisp) begin
        disp_rdata <= oor_q ? '0 : mem_rdata;
      end
      cpu_rvalid <= (owner_q == OwnCpu) && rd_q;
      if ((owner_q == OwnCpu) && rd_q) begin
        cpu_rdata <= oor_q ? '0 : mem_rdata;
      end
      cpu_err   <= (owner_q == OwnCpu) && oor_q;
      disp_miss <= miss_q;
    end
  end

  fb_sat_counter #(
    .WIDTH(16)
  ) u_miss_counter (
    .clock(clock),
    .clear(reset),
    .inc  (miss_q),
    .count(miss_count)
  );

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Self-checking bench for fb_access_arbiter: directed scenarios plus a random phase,
// all checked against a transaction-level model of the arbitration rules.
module tb_fb_access_arbiter;
  import fb_pkg::*;

  localparam int unsigned MAXS = 16;
  localparam int unsigned FBS  = 307200;

  logic        clock = 1'b0;
  logic        reset;
  logic        disp_req, cpu_valid, cpu_we;
  logic [18:0] disp_addr, cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  disp_rdata, cpu_rdata, mem_wdata, mem_rdata;
  logic        disp_rvalid, disp_miss, cpu_ready, cpu_rvalid, cpu_err, mem_en, mem_we;
  logic [18:0] mem_addr;
  logic [15:0] miss_count;

  // Second instance with MAX_STARVE=0: every cycle is a forced miss.
  logic        disp_req2, cpu_valid2, cpu_we2;
  logic [18:0] disp_addr2, cpu_addr2, mem_addr2;
  logic [7:0]  cpu_wdata2, disp_rdata2, cpu_rdata2, mem_wdata2, mem_rdata2;
  logic        disp_rvalid2, disp_miss2, cpu_ready2, cpu_rvalid2, cpu_err2, mem_en2, mem_we2;
  logic [15:0] miss_count2;

  always #5 clock = ~clock;

  fb_access_arbiter #(.MAX_STARVE(MAXS), .FB_SIZE(FBS)) dut (
    .clock(clock), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata),
    .disp_rvalid(disp_rvalid), .disp_miss(disp_miss),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .miss_count(miss_count)
  );

  fb_access_arbiter #(.MAX_STARVE(0), .FB_SIZE(FBS)) dut2 (
    .clock(clock), .reset(reset),
    .disp_req(disp_req2), .disp_addr(disp_addr2), .disp_rdata(disp_rdata2),
    .disp_rvalid(disp_rvalid2), .disp_miss(disp_miss2),
    .cpu_valid(cpu_valid2), .cpu_ready(cpu_ready2), .cpu_we(cpu_we2), .cpu_addr(cpu_addr2),
    .cpu_wdata(cpu_wdata2), .cpu_rdata(cpu_rdata2), .cpu_rvalid(cpu_rvalid2),
    .cpu_err(cpu_err2), .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .miss_count(miss_count2)
  );

  assign mem_rdata2 = 8'h00;

  // Power-up RAM image; address 5 holds 0xA5.
  function automatic logic [7:0] init_val(logic [18:0] a);
    return (a == 19'd5) ? 8'hA5 : (a[7:0] ^ 8'h5A);
  endfunction

  // Bench RAM: writes on the clock edge, read data presented for the following edge.
  logic [7:0] ram [0:524287];
  bit         wr  [0:524287];
  always @(posedge clock) begin
    if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr[mem_addr]  <= 1'b1;
    end
  end
  always @(negedge clock) mem_rdata <= wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);

  // ---------------- reference model ----------------
  typedef struct {
    bit          vld;
    bit          disp;
    bit          cpu;
    bit          we;
    bit          oor;
    bit          miss;
    logic [18:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } rec_t;

  rec_t       s1, s2;           // transactions one and two cycles after grant
  int         starve;
  int         mc;
  logic [7:0] last_d, last_c;
  logic [7:0] mdl_mem [int];
  int         errs = 0;
  int         checks = 0;

  function automatic rec_t none_rec();
    rec_t r;
    r = '{vld: 0, disp: 0, cpu: 0, we: 0, oor: 0, miss: 0, addr: '0, wdata: '0, rdata: '0};
    return r;
  endfunction

  function automatic logic [7:0] mdl_read(logic [18:0] a);
    return mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic [18:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel <= 6) return 19'($urandom_range(0, 31));
    if (sel == 7) return 19'(FBS - 1);
    if (sel == 8) return 19'(FBS + $urandom_range(0, 3));
    return 19'($urandom_range(0, 524287));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    logic exp_en, exp_we;
    exp_en = s1.vld && !s1.oor;
    exp_we = exp_en && s1.cpu && s1.we;
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    if (exp_en) chk("mem_addr", 32'(mem_addr), 32'(s1.addr));
    if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(s1.wdata));
    chk("disp_rvalid", 32'(disp_rvalid), 32'(s2.disp));
    chk("disp_rdata", 32'(disp_rdata), 32'(last_d));
    chk("disp_miss", 32'(disp_miss), 32'(s2.miss));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(s2.cpu && !s2.we));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(last_c));
    chk("cpu_err", 32'(cpu_err), 32'(s2.cpu && s2.oor));
    chk("miss_count", 32'(miss_count), 32'(mc));
  endtask

  // One clock: check registered outputs, apply inputs, check cpu_ready, advance model.
  task automatic cycle(input logic dr, input logic [18:0] da, input logic cv, input logic cw,
                       input logic [18:0] ca, input logic [7:0] cd, output logic rdy);
    rec_t cur;
    logic frc, gd, gc;
    check_regs();
    disp_req = dr; disp_addr = da; cpu_valid = cv; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    #1;
    frc = cv && (starve == int'(MAXS));
    gd  = dr && !frc;
    gc  = cv && !gd;
    chk("cpu_ready", 32'(cpu_ready), 32'(gc));
    rdy = gc;
    cur = none_rec();
    if (gd || gc) begin
      cur.vld   = 1'b1;
      cur.disp  = gd;
      cur.cpu   = gc;
      cur.we    = gc && cw;
      cur.addr  = gd ? da : ca;
      cur.oor   = (32'(cur.addr) >= FBS);
      cur.miss  = dr && gc;
      cur.wdata = cd;
      if (!cur.oor && cur.we) mdl_mem[int'(cur.addr)] = cd;
      cur.rdata = cur.oor ? 8'h00 : mdl_read(cur.addr);
    end
    if (!cv || gc) starve = 0;
    else if (starve < int'(MAXS)) starve++;
    @(posedge clock);
    s2 = s1;
    s1 = cur;
    if (s2.disp) last_d = s2.rdata;
    if (s2.cpu && !s2.we) last_c = s2.rdata;
    if (s2.miss && mc < 65535) mc++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    logic r;
    repeat (n) cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, r);
  endtask

  task automatic do_reset(input int n, input bit check_first);
    if (check_first) check_regs();
    reset = 1'b1; disp_req = 1'b0; cpu_valid = 1'b1; cpu_we = 1'b0;
    #1;
    chk("cpu_ready_in_reset", 32'(cpu_ready), 32'(0));
    repeat (n) @(posedge clock);
    s1 = none_rec(); s2 = none_rec(); starve = 0; mc = 0; last_d = '0; last_c = '0;
    @(negedge clock);
    reset = 1'b0; cpu_valid = 1'b0;
  endtask

  // CPU transaction held until accepted, bounded to 64 cycles.
  task automatic cpu_txn(input logic we, input logic [18:0] a, input logic [7:0] d);
    logic r;
    bit got;
    got = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      cycle(1'b0, '0, 1'b1, we, a, d, r);
      got = r;
    end
    chk("cpu_txn_accepted", 32'(got), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r, cv, pend, pwe, dr;
    logic [18:0] pa, da;
    logic [7:0] pd;
    int gcyc;

    disp_req2 = 0; cpu_valid2 = 0; cpu_we2 = 0; disp_addr2 = '0; cpu_addr2 = '0; cpu_wdata2 = '0;
    disp_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    s1 = none_rec(); s2 = none_rec();
    do_reset(2, 1'b0);

    // Display read of address 5 returns 0xA5 two cycles after grant.
    cycle(1'b1, 19'd5, 1'b0, 1'b0, '0, '0, r);
    idle(2);
    chk("disp_a5", 32'(disp_rdata), 32'h0A5);

    // CPU write then read back at address 100.
    cpu_txn(1'b1, 19'd100, 8'h3C);
    idle(1);
    cpu_txn(1'b0, 19'd100, 8'h00);
    idle(2);
    chk("cpu_rd100", 32'(cpu_rdata), 32'h03C);

    // Display hogging the port: CPU is forced through at cycle 16.
    cv = 1'b1; gcyc = -1;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 19'(i), cv, 1'b0, 19'd200, 8'h00, r);
      if (r && cv) begin gcyc = i; cv = 1'b0; end
    end
    idle(3);
    chk("forced_grant_cycle", 32'(gcyc), 32'd16);
    chk("miss_after_starve", 32'(miss_count), 32'd1);

    // Out-of-range CPU write and display read.
    cpu_txn(1'b1, 19'(FBS), 8'h77);
    cycle(1'b1, 19'(FBS + 5), 1'b0, 1'b0, '0, '0, r);
    idle(2);
    chk("oor_disp_data", 32'(disp_rdata), 32'd0);

    // Reset one cycle after a display grant drops it.
    cycle(1'b1, 19'd7, 1'b0, 1'b0, '0, '0, r);
    do_reset(1, 1'b1);
    idle(3);

    // Random traffic with CPU requests held until accepted.
    pend = 0; pwe = 0; pa = '0; pd = '0;
    for (int i = 0; i < 800; i++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1'b1; pwe = 1'($urandom_range(0, 1)); pa = rand_addr(); pd = 8'($urandom);
      end
      dr = ($urandom_range(0, 3) != 0);
      da = rand_addr();
      cycle(dr, da, pend, pwe, pa, pd, r);
      if (r) pend = 1'b0;
    end
    idle(3);

    // Saturation: one forced miss per cycle on the MAX_STARVE=0 instance.
    chk("sat_start", 32'(miss_count2), 32'd0);
    disp_req2 = 1'b1; cpu_valid2 = 1'b1; cpu_we2 = 1'b1;
    for (int k = 1; k <= 65541; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k <= 3 || k == 1000 || k >= 65535) begin
        chk("sat_count", 32'(miss_count2), (k - 1 > 65535) ? 32'd65535 : 32'(k - 1));
        chk("sat_miss", 32'(disp_miss2), 32'(k >= 2));
        chk("sat_rvalid", 32'(disp_rvalid2), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fb_access_arbiter.md
FB_ACCESS_ARBITER -- requirements
Module: fb_access_arbiter

Interface
REQ-001 SHALL have parameter: MAX_STARVE, default 16, max consecutive cycles a pending CPU request waits behind display before a forced CPU grant.
REQ-002 SHALL have parameter: FB_SIZE, default 307200, number of valid framebuffer words (640x480).
REQ-003 SHALL have ports: clock  in  1  single clock for all logic; reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: disp_req  in  1  display read request this cycle; disp_addr  in  19  display read address.
REQ-005 SHALL have ports: disp_rdata  out  8  display read data; disp_rvalid  out  1  disp_rdata valid; disp_miss  out  1  display request dropped.
REQ-006 SHALL have ports: cpu_valid  in  1  CPU request pending; cpu_ready  out  1  CPU request accepted this cycle; cpu_we  in  1  1=write, 0=read; cpu_addr  in  19  CPU address; cpu_wdata  in  8  CPU write data.
REQ-007 SHALL have ports: cpu_rdata  out  8  CPU read data; cpu_rvalid  out  1  cpu_rdata valid; cpu_err  out  1  out-of-range CPU access.
REQ-008 SHALL have ports: mem_en  out  1  RAM access strobe; mem_we  out  1  RAM write enable; mem_addr  out  19  RAM address; mem_wdata  out  8  RAM write data; mem_rdata  in  8  RAM read data, valid 1 cycle after mem_en read.
REQ-009 SHALL have port: miss_count  out  16  saturating count of disp_miss pulses since reset.

Function
REQ-010 SHALL compute grant in cycle N combinationally from inputs and starve_cnt: DISP if disp_req and not (cpu_valid and starve_cnt==MAX_STARVE); else CPU if cpu_valid; else NONE.
REQ-011 SHALL assert cpu_ready in cycle N exactly when grant is CPU; a CPU transaction completes on cpu_valid and cpu_ready both high.
REQ-012 SHALL require cpu_valid and its address/data held stable until cpu_ready; the block is not required to handle a dropped cpu_valid.
REQ-013 SHALL increment starve_cnt each cycle cpu_valid is high and grant is not CPU, clear it on CPU grant or on cpu_valid low, and never exceed MAX_STARVE.
REQ-014 SHALL register the granted access to mem_en/mem_we/mem_addr/mem_wdata in cycle N+1; mem_en low for grant NONE.
REQ-015 SHALL issue no RAM access (mem_en low in N+1) for any granted address >= FB_SIZE.
REQ-016 SHALL record the owner (DISP/CPU/NONE) and the out-of-range flag of each issued read for one cycle and route mem_rdata in N+2 to the owner only.
REQ-017 SHALL assert disp_rvalid in N+2 for every DISP grant, with disp_rdata=mem_rdata, or 0 if the address was out of range.
REQ-018 SHALL assert cpu_rvalid in N+2 for every CPU read grant, with cpu_rdata=mem_rdata, or 0 if the address was out of range.
REQ-019 SHALL pulse cpu_err for one cycle in N+2 for any CPU grant with address >= FB_SIZE, read or write; writes produce no cpu_rvalid.
REQ-020 SHALL, when disp_req is high in N and grant is a forced CPU grant (REQ-010), pulse disp_miss in N+2 with disp_rvalid low, and increment miss_count.
REQ-021 SHALL saturate miss_count at 16'hFFFF.
REQ-022 SHALL register all outputs except cpu_ready; disp_rdata/cpu_rdata SHALL hold their last value when the matching valid is low.
REQ-023 SHALL never assert disp_rvalid and disp_miss in the same cycle, nor more than one of DISP/CPU access per cycle.

Reset
REQ-024 SHALL, on reset high at a clock edge, clear mem_en, mem_we, mem_addr, mem_wdata, disp_rvalid, disp_rdata, disp_miss, cpu_rvalid, cpu_rdata, cpu_err, miss_count, starve_cnt and the owner pipeline to zero/NONE.
REQ-025 SHALL hold cpu_ready low while reset is high.
REQ-026 SHALL drop requests in flight at reset: no rvalid, miss or err pulse attributable to a pre-reset grant.

Structure
REQ-027 SHALL take FB_WIDTH=640, FB_HEIGHT=480, FB_SIZE, ADDR_W=19, DATA_W=8 and the owner enum (NONE, DISP, CPU) from shared package fb_pkg.
REQ-028 SHALL implement miss_count as sub-module fb_sat_counter (width parameter, synchronous clear, increment enable).

Verification
REQ-029 SHALL cover: disp_req high 1 cycle at addr 0x00005, RAM holds 0xA5 there -> mem_en/mem_addr=5 at N+1, disp_rvalid=1 and disp_rdata=0xA5 at N+2.
REQ-030 SHALL cover: CPU write 0x3C to addr 100 with no disp_req -> cpu_ready at N, mem_we=1 at N+1; CPU read of addr 100 afterwards -> cpu_rvalid with 0x3C two cycles after grant.
REQ-031 SHALL cover: disp_req held high 40 cycles, cpu_valid high from cycle 0, MAX_STARVE=16 -> cpu_ready in cycle 16, disp_miss 2 cycles later, miss_count=1.
REQ-032 SHALL cover: CPU write to addr 307200 -> cpu_ready, mem_en low, cpu_err 1 cycle; display read of 307205 -> disp_rvalid with data 0.
REQ-033 SHALL cover: reset asserted 1 cycle after a DISP grant -> no disp_rvalid afterwards, all outputs 0 after reset.
REQ-034 SHALL cover: 65540 forced misses -> miss_count stays 16'hFFFF.
